// File: rtl/lsu_ecc_scrub_wb.sv
`default_nettype none
// ============================================================================
// Module      : lsu_ecc_scrub_wb
// Description : DCCM ECC scrub writeback queue. Corrected words flagged by a
//               single-bit ECC error in dc3 are re-encoded with 39/32 SECDED
//               check bits and queued; a request/grant port drains the queue
//               into the DCCM write port in FIFO order.
//               Optional feature macro: RV_LSU_ECC_WB_COUNT_EN enables a
//               saturating 16-bit completed-writeback counter.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_ecc_scrub_wb #(
    parameter int WB_DEPTH        = 4,
    parameter int DCCM_DATA_WIDTH = 32,
    parameter int DCCM_ECC_WIDTH  = 7,
    parameter int RV_DCCM_BITS    = 16
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic                       single_ecc_error_lo_dc3,
    input  logic                       single_ecc_error_hi_dc3,
    input  logic                       lsu_double_ecc_error_dc3,
    input  logic                       dec_tlu_core_ecc_disable,
    input  logic [RV_DCCM_BITS-1:0]    lsu_addr_dc3,
    input  logic [RV_DCCM_BITS-1:0]    end_addr_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0] store_ecc_datafn_lo_dc3,
    input  logic [DCCM_DATA_WIDTH-1:0] store_ecc_datafn_hi_dc3,
    input  logic                       ecc_wb_gnt,
    output logic                       ecc_wb_req,
    output logic [RV_DCCM_BITS-1:0]    ecc_wb_addr,
    output logic [DCCM_DATA_WIDTH-1:0] ecc_wb_data,
    output logic [DCCM_ECC_WIDTH-1:0]  ecc_wb_ecc,
    output logic                       ecc_wb_busy,
    output logic                       ecc_wb_overflow,
    output logic [15:0]                ecc_wb_count
);

    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]          DEPTH_EXT   = (CNT_W + 1)'(WB_DEPTH);
    localparam logic [CNT_W:0]          ONE_EXT     = (CNT_W + 1)'(1);
    localparam logic [CNT_W-1:0]        BUSY_THRESH = CNT_W'(WB_DEPTH - 2);
    localparam logic [RV_DCCM_BITS-1:0] ADDR_MASK   = ~(RV_DCCM_BITS'(3));

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t state, state_next;

    logic [RV_DCCM_BITS-1:0]    q_addr [WB_DEPTH];
    logic [DCCM_DATA_WIDTH-1:0] q_data [WB_DEPTH];
    logic [DCCM_ECC_WIDTH-1:0]  q_ecc  [WB_DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_ptr_hi;
    logic [CNT_W-1:0] count, count_next;
    logic [CNT_W:0]   free_slots;
    logic [1:0]       n_acc;
    logic             enq_ok, push_lo, push_hi, acc_lo, acc_hi, dropped, pop;
    logic [RV_DCCM_BITS-1:0]   addr_lo, addr_hi;
    logic [DCCM_ECC_WIDTH-1:0] ecc_lo, ecc_hi;

    // Hamming SECDED: data bits occupy the non-power-of-two codeword positions
    // starting at 3; check bit k is the parity of positions with bit k set and
    // the top check bit is overall parity of data plus the Hamming bits.
    function automatic logic [DCCM_ECC_WIDTH-1:0] secded_encode(
        input logic [DCCM_DATA_WIDTH-1:0] din
    );
        logic [DCCM_ECC_WIDTH-1:0] ecc;
        int pos;
        ecc = '0;
        pos = 3;
        for (int i = 0; i < DCCM_DATA_WIDTH; i++) begin
            for (int k = 0; k < DCCM_ECC_WIDTH - 1; k++) begin
                if (pos[k]) ecc[k] = ecc[k] ^ din[i];
            end
            pos = pos + 1;
            if ((pos & (pos - 1)) == 0) pos = pos + 1;
        end
        ecc[DCCM_ECC_WIDTH-1] = (^din) ^ (^ecc[DCCM_ECC_WIDTH-2:0]);
        return ecc;
    endfunction

    assign enq_ok  = ~lsu_double_ecc_error_dc3 & ~dec_tlu_core_ecc_disable;
    assign push_lo = enq_ok & single_ecc_error_lo_dc3;
    assign push_hi = enq_ok & single_ecc_error_hi_dc3;
    assign addr_lo = lsu_addr_dc3 & ADDR_MASK;
    assign addr_hi = end_addr_dc3 & ADDR_MASK;
    assign ecc_lo  = secded_encode(store_ecc_datafn_lo_dc3);
    assign ecc_hi  = secded_encode(store_ecc_datafn_hi_dc3);

    assign ecc_wb_req = (state == REQ);
    assign pop        = ecc_wb_req & ecc_wb_gnt;

    // A slot freed by this cycle's pop is reusable by this cycle's enqueue;
    // the lo entry claims space first so a lone free slot goes to it.
    always_comb begin
        free_slots = DEPTH_EXT - {1'b0, count} + {{CNT_W{1'b0}}, pop};
        acc_lo     = push_lo & (free_slots != '0);
        acc_hi     = push_hi & (acc_lo ? (free_slots > ONE_EXT) : (free_slots != '0));
        dropped    = (push_lo & ~acc_lo) | (push_hi & ~acc_hi);
        n_acc      = {1'b0, acc_lo} + {1'b0, acc_hi};
        wr_ptr_hi  = wr_ptr + PTR_W'(acc_lo);
        count_next = count + CNT_W'(n_acc) - CNT_W'(pop);
    end

    // Entry storage; contents are only observable through the gated outputs.
    always_ff @(posedge clk) begin
        if (acc_lo) begin
            q_addr[wr_ptr] <= addr_lo;
            q_data[wr_ptr] <= store_ecc_datafn_lo_dc3;
            q_ecc[wr_ptr]  <= ecc_lo;
        end
        if (acc_hi) begin
            q_addr[wr_ptr_hi] <= addr_hi;
            q_data[wr_ptr_hi] <= store_ecc_datafn_hi_dc3;
            q_ecc[wr_ptr_hi]  <= ecc_hi;
        end
    end

    // Queue pointers, occupancy, FSM state and the registered overflow pulse.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state           <= IDLE;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            ecc_wb_overflow <= 1'b0;
        end else begin
            state           <= state_next;
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            wr_ptr          <= wr_ptr + PTR_W'(n_acc);
            count           <= count_next;
            ecc_wb_overflow <= dropped;
        end
    end

    // Requesting whenever the queue will hold an entry, so an enqueue into an
    // empty queue raises the request on the very next cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != '0) state_next = REQ;
            REQ:     if (count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Head entry is presented only while requesting, which also zeroes it in reset.
    always_comb begin
        ecc_wb_addr = '0;
        ecc_wb_data = '0;
        ecc_wb_ecc  = '0;
        if (ecc_wb_req) begin
            ecc_wb_addr = q_addr[rd_ptr];
            ecc_wb_data = q_data[rd_ptr];
            ecc_wb_ecc  = q_ecc[rd_ptr];
        end
    end

    assign ecc_wb_busy = (count > BUSY_THRESH);

`ifdef RV_LSU_ECC_WB_COUNT_EN
    logic [15:0] wb_count;

    // Saturating count of completed writebacks.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wb_count <= 16'h0000;
        end else if (pop && (wb_count != 16'hFFFF)) begin
            wb_count <= wb_count + 16'd1;
        end
    end

    assign ecc_wb_count = wb_count;
`else
    assign ecc_wb_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_ecc_scrub_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_ecc_scrub_wb
// Description : Self-checking bench for lsu_ecc_scrub_wb. Expected writebacks
//               are queued when SEC stimulus is driven and compared as the
//               DUT completes each request/grant handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_ecc_scrub_wb;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int EW    = 7;
    localparam int AW    = 16;

    logic          clk = 1'b0;
    logic          rst_l = 1'b0;
    logic          sec_lo = 1'b0, sec_hi = 1'b0, ded = 1'b0, dis = 1'b0;
    logic [AW-1:0] la = '0, ea = '0;
    logic [DW-1:0] dlo = '0, dhi = '0;
    logic          gnt = 1'b0;
    logic          req, busy, ovf;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [EW-1:0] wb_ecc;
    logic [15:0]   wb_count;

    always #5 clk = ~clk;

    lsu_ecc_scrub_wb #(
        .WB_DEPTH        (DEPTH),
        .DCCM_DATA_WIDTH (DW),
        .DCCM_ECC_WIDTH  (EW),
        .RV_DCCM_BITS    (AW)
    ) dut (
        .clk                      (clk),
        .rst_l                    (rst_l),
        .single_ecc_error_lo_dc3  (sec_lo),
        .single_ecc_error_hi_dc3  (sec_hi),
        .lsu_double_ecc_error_dc3 (ded),
        .dec_tlu_core_ecc_disable (dis),
        .lsu_addr_dc3             (la),
        .end_addr_dc3             (ea),
        .store_ecc_datafn_lo_dc3  (dlo),
        .store_ecc_datafn_hi_dc3  (dhi),
        .ecc_wb_gnt               (gnt),
        .ecc_wb_req               (req),
        .ecc_wb_addr              (wb_addr),
        .ecc_wb_data              (wb_data),
        .ecc_wb_ecc               (wb_ecc),
        .ecc_wb_busy              (busy),
        .ecc_wb_overflow          (ovf),
        .ecc_wb_count             (wb_count)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [EW-1:0] ecc;
    } ent_t;

    ent_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    bit   ovf_exp = 1'b0;
    int   exp_cnt = 0;
    bit   mon_en  = 1'b0;

    // Reference 39/32 SECDED check bits from per-bit parity masks.
    function automatic logic [6:0] ref_ecc(input logic [31:0] d);
        logic [6:0] e;
        e[0] = ^(d & 32'h56AAAD5B);
        e[1] = ^(d & 32'h9B33366D);
        e[2] = ^(d & 32'hE3C3C78E);
        e[3] = ^(d & 32'h03FC07F0);
        e[4] = ^(d & 32'h03FFF800);
        e[5] = ^(d & 32'hFC000000);
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic ent_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ent_t e;
        e.addr = {a[AW-1:2], 2'b00};
        e.data = d;
        e.ecc  = ref_ecc(d);
        return e;
    endfunction

    // Advance one clock with the currently driven inputs; the model decides
    // which SEC entries fit and queues them as expected writebacks.
    task automatic tick();
        bit   pop_m, enq, kl, kh, drop;
        int   free;
        ent_t el, eh;
        enq   = !ded && !dis;
        pop_m = gnt && (sb.size() != 0);
        free  = DEPTH - sb.size() + (pop_m ? 1 : 0);
        kl = 1'b0; kh = 1'b0; drop = 1'b0;
        if (enq && sec_lo) begin
            if (free > 0) begin kl = 1'b1; free--; end else drop = 1'b1;
        end
        if (enq && sec_hi) begin
            if (free > 0) kh = 1'b1; else drop = 1'b1;
        end
        el = mk(la, dlo);
        eh = mk(ea, dhi);
        @(posedge clk);
        #1;
        if (kl) sb.push_back(el);
        if (kh) sb.push_back(eh);
        ovf_exp = drop;
        sec_lo  = 1'b0;
        sec_hi  = 1'b0;
    endtask

    // Per-cycle monitor: handshake data against the scoreboard plus status outputs.
    always @(negedge clk) begin
        if (mon_en && rst_l) begin
            checks++;
            if (req !== (sb.size() != 0)) begin
                errors++;
                $display("FAIL req_state t=%0t got %b exp %b", $time, req, sb.size() != 0);
            end
            checks++;
            if (busy !== ((DEPTH - sb.size()) < 2)) begin
                errors++;
                $display("FAIL busy t=%0t got %b exp %b", $time, busy, (DEPTH - sb.size()) < 2);
            end
            checks++;
            if (ovf !== ovf_exp) begin
                errors++;
                $display("FAIL overflow t=%0t got %b exp %b", $time, ovf, ovf_exp);
            end
            checks++;
            if (wb_count !== 16'(exp_cnt)) begin
                errors++;
                $display("FAIL wb_count t=%0t got %0d exp %0d", $time, wb_count, exp_cnt);
            end
            if (req === 1'b1 && gnt === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write t=%0t addr %h", $time, wb_addr);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    if (wb_addr !== e.addr || wb_data !== e.data || wb_ecc !== e.ecc) begin
                        errors++;
                        $display("FAIL write_entry t=%0t got %h/%h/%h exp %h/%h/%h", $time,
                                 wb_addr, wb_data, wb_ecc, e.addr, e.data, e.ecc);
                    end
`ifdef RV_LSU_ECC_WB_COUNT_EN
                    if (exp_cnt != 65535) exp_cnt++;
`endif
                end
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        tick();
        checks++;
        if (sb.size() != 0 || req !== 1'b0) begin
            errors++;
            $display("FAIL %s_drain got %0d left req %b exp 0 left req 0", name, sb.size(), req);
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0 || wb_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_status got req %b busy %b ovf %b cnt %h exp 0", req, busy, ovf, wb_count);
        end
        checks++;
        if (wb_addr !== '0 || wb_data !== '0 || wb_ecc !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h/%h/%h exp 0/0/0", wb_addr, wb_data, wb_ecc);
        end
        rst_l  = 1'b1;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_single_lo();
        gnt = 1'b1; la = 16'hF006; dlo = 32'h0; sec_lo = 1'b1;
        tick();
        checks++;
        if (req !== 1'b1 || wb_addr !== 16'hF004 || wb_data !== 32'h0 || wb_ecc !== 7'h00) begin
            errors++;
            $display("FAIL single_latency got req %b addr %h data %h ecc %h exp 1 f004 0 00",
                     req, wb_addr, wb_data, wb_ecc);
        end
        tick();
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL single_req_low got %b exp 0", req);
        end
        gnt = 1'b0;
    endtask

    task automatic test_dual();
        gnt = 1'b0; la = 16'h00FE; ea = 16'h0101;
        dlo = 32'hDEAD_BEEF; dhi = 32'h1234_5678;
        sec_lo = 1'b1; sec_hi = 1'b1;
        tick();
        repeat (2) tick();
        checks++;
        if (wb_addr !== 16'h00FC || wb_ecc !== ref_ecc(32'hDEAD_BEEF)) begin
            errors++;
            $display("FAIL dual_lo_first got %h/%h exp 00fc/%h", wb_addr, wb_ecc, ref_ecc(32'hDEAD_BEEF));
        end
        gnt = 1'b1;
        tick();
        checks++;
        if (req !== 1'b1 || wb_addr !== 16'h0100 || wb_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL dual_hi_next got req %b addr %h data %h exp 1 0100 12345678", req, wb_addr, wb_data);
        end
        tick();
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL dual_idle got %b exp 0", req);
        end
        gnt = 1'b0;
    endtask

    task automatic test_overflow();
        gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            la = 16'h0200 + 16'(i * 4); dlo = 32'hA5A5_0000 + 32'(i); sec_lo = 1'b1;
            tick();
            if (i == 1) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_2 got %b exp 0", busy);
                end
            end
            if (i == 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_3 got %b exp 1", busy);
                end
            end
        end
        checks++;
        if (ovf !== 1'b1 || sb.size() != 4) begin
            errors++;
            $display("FAIL overflow_pulse got %b kept %0d exp 1 kept 4", ovf, sb.size());
        end
        tick();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_one_cycle got %b exp 0", ovf);
        end
        gnt = 1'b1;
        drain("overflow");
        gnt = 1'b0;
    endtask

    task automatic test_block();
        gnt = 1'b0; la = 16'h0300; dlo = 32'h1; sec_lo = 1'b1; ded = 1'b1;
        tick();
        ded = 1'b0; dis = 1'b1; sec_lo = 1'b1; sec_hi = 1'b1; ea = 16'h0304;
        tick();
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL blocked_enqueue got req %b exp 0", req);
        end
        dis = 1'b0; sec_lo = 1'b1; sec_hi = 1'b1; dlo = 32'h0F0F_0F0F; dhi = 32'hF0F0_F0F0;
        tick();
        dis = 1'b1; gnt = 1'b1;
        drain("disabled");
        dis = 1'b0; gnt = 1'b0;
    endtask

    task automatic test_reset_mid();
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            la = 16'h0400 + 16'(i * 4); dlo = 32'(i + 7); sec_lo = 1'b1;
            tick();
        end
        rst_l = 1'b0;
        sb.delete();
        exp_cnt = 0;
        ovf_exp = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0 || wb_addr !== '0 || wb_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid got req %b addr %h cnt %h exp 0 0 0", req, wb_addr, wb_count);
        end
        tick();
        rst_l = 1'b1;
        gnt = 1'b1;
        repeat (4) tick();
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_reissue got %b exp 0", req);
        end
        gnt = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Full queue with a pop and a single enqueue in one cycle must not overflow.
        gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            la = 16'h0500 + 16'(i * 4); dlo = 32'hC0DE_0000 + 32'(i); sec_lo = 1'b1;
            tick();
        end
        gnt = 1'b1; la = 16'h0510; dlo = 32'hC0DE_0004; sec_lo = 1'b1;
        tick();
        checks++;
        if (ovf !== 1'b0 || sb.size() != 4) begin
            errors++;
            $display("FAIL full_pop_enq got ovf %b kept %0d exp 0 kept 4", ovf, sb.size());
        end
        for (int c = 0; c < 300; c++) begin
            gnt    = ($urandom_range(0, 3) != 0);
            sec_lo = ($urandom_range(0, 2) == 0);
            sec_hi = ($urandom_range(0, 2) == 0);
            ded    = ($urandom_range(0, 9) == 0);
            dis    = ($urandom_range(0, 9) == 0);
            la     = 16'($urandom);
            ea     = 16'($urandom);
            dlo    = $urandom;
            dhi    = $urandom;
            tick();
        end
        ded = 1'b0; dis = 1'b0; gnt = 1'b1;
        drain("random");
        gnt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_lo();
        test_dual();
        test_overflow();
        test_block();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/lsu_ecc_scrub_wb.md
LSU_ECC_SCRUB_WB -- requirements
Module: lsu_ecc_scrub_wb

Interface
REQ-001 SHALL have parameter WB_DEPTH, default 4, meaning correction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter DCCM_DATA_WIDTH, default 32, meaning bank data width in bits.
REQ-003 SHALL have parameter DCCM_ECC_WIDTH, default 7, meaning SECDED check bits per bank word.
REQ-004 SHALL provide the following ports:
- clk  in  1  core clock.
- rst_l  in  1  reset, asynchronous, active-low.
- single_ecc_error_lo_dc3  in  1  SEC on lo bank.
- single_ecc_error_hi_dc3  in  1  SEC on hi bank.
- lsu_double_ecc_error_dc3  in  1  DED on either bank.
- dec_tlu_core_ecc_disable  in  1  ECC disable.
- lsu_addr_dc3  in  RV_DCCM_BITS  start address.
- end_addr_dc3  in  RV_DCCM_BITS  end address.
- store_ecc_datafn_lo_dc3  in  DCCM_DATA_WIDTH  corrected lo word.
- store_ecc_datafn_hi_dc3  in  DCCM_DATA_WIDTH  corrected hi word.
- ecc_wb_gnt  in  1  DCCM write port granted.
- ecc_wb_req  out  1  write request.
- ecc_wb_addr  out  RV_DCCM_BITS  write address, bits [1:0] zero.
- ecc_wb_data  out  DCCM_DATA_WIDTH  write data.
- ecc_wb_ecc  out  DCCM_ECC_WIDTH  write check bits.
- ecc_wb_busy  out  1  fewer than 2 free entries.
- ecc_wb_overflow  out  1  one-cycle pulse on dropped entry.
- ecc_wb_count  out  16  completed writebacks.

Function
REQ-005 SHALL define enq_ok = ~lsu_double_ecc_error_dc3 & ~dec_tlu_core_ecc_disable.
REQ-006 SHALL, when enq_ok & single_ecc_error_lo_dc3, enqueue {lsu_addr_dc3 with [1:0]=0, store_ecc_datafn_lo_dc3}.
REQ-007 SHALL, when enq_ok & single_ecc_error_hi_dc3, enqueue {end_addr_dc3 with [1:0]=0, store_ecc_datafn_hi_dc3}; when both errors occur in one cycle, the lo entry SHALL be ordered ahead of the hi entry.
REQ-008 SHALL compute the check bits at enqueue time with the 39/32 SECDED encoding of rvecc_encode, and store them with the entry.
REQ-009 SHALL be a circular FIFO with wrapping WB_DEPTH-sized read and write pointers and a count register of width clog2(WB_DEPTH)+1.
REQ-010 SHALL drop any entry that does not fit, and pulse ecc_wb_overflow high for exactly one cycle. If only one slot is free on a dual enqueue, the lo entry SHALL be kept and the hi entry dropped.
REQ-011 SHALL drive ecc_wb_busy = (WB_DEPTH - count) < 2 combinationally from registered count.
REQ-012 SHALL implement an FSM with states IDLE and REQ. IDLE->REQ on the cycle after count becomes nonzero. REQ->IDLE when gnt pops the last entry and no enqueue occurs in the same cycle.
REQ-013 SHALL drive ecc_wb_req=1 only in REQ, with addr, data and ecc taken from the head entry and held stable until ecc_wb_gnt.
REQ-014 SHALL treat ecc_wb_req & ecc_wb_gnt as a pop in that cycle. The next entry, if any, SHALL be presented in the following cycle with req held high (back-to-back allowed).
REQ-015 SHALL ignore ecc_wb_gnt while ecc_wb_req=0.
REQ-016 SHALL, on simultaneous enqueue and pop, net the count change; a full queue with a pop and a single enqueue SHALL not overflow.
REQ-017 SHALL continue draining queued entries while dec_tlu_core_ecc_disable=1; only new enqueues are blocked.
REQ-018 SHALL keep the latency from an SEC in dc3 to ecc_wb_req high at 1 cycle when the queue is empty.

Reset
REQ-019 SHALL asynchronously clear on rst_l=0: FSM to IDLE, pointers, count, ecc_wb_req, ecc_wb_overflow, ecc_wb_busy and ecc_wb_count to 0.
REQ-020 SHALL drive ecc_wb_addr, ecc_wb_data and ecc_wb_ecc to 0 during reset.
REQ-021 SHALL discard any pending or in-flight request when reset asserts, and SHALL not re-issue it after reset.

Configuration
REQ-022 SHALL, with RV_LSU_ECC_WB_COUNT_EN defined, increment ecc_wb_count on each pop, saturating at 16'hFFFF.
REQ-023 SHALL, without RV_LSU_ECC_WB_COUNT_EN, tie ecc_wb_count to 0 and instantiate no counter flops.

Verification
REQ-024 Single lo SEC, addr 0x0000_F006, data 0x0000_0000, gnt held 1 -> req high next cycle with addr 0x0000_F004, data 0, ecc 7'h00; req low the cycle after.
REQ-025 Lo and hi SEC in one cycle, lsu_addr 0x...0FE, end_addr 0x...101, gnt low for 3 cycles then 1 -> lo entry (0x...0FC) issued first, then hi entry (0x...100) in the next cycle, then IDLE.
REQ-026 With WB_DEPTH=4, 5 lo SECs and gnt low -> busy=1 once count reaches 3; the 5th is dropped with overflow pulse=1 for 1 cycle; 4 writes drain in order.
REQ-027 SEC together with DED, or SEC with ecc_disable=1 -> no enqueue and req stays 0; with 2 entries queued and ecc_disable=1 -> both still drain.
REQ-028 rst_l low mid-REQ with 3 entries queued -> req=0 immediately; after release no writes issue; with COUNT_EN defined, count returns to 0.
